// File: rtl/apb_modport_bridge.sv
// AHB-Lite slave to APB master bridge: single transfers in the 0x8xxx_xxxx window
// become two-cycle APB SETUP/ENABLE accesses on one of four 64 MB slots.
module apb_modport_bridge (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [3:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_WSETUP  = 3'd2,
    ST_WENABLE = 3'd3,
    ST_RSETUP  = 3'd4,
    ST_RENABLE = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        valid_s;
  logic        accept_s;
  logic [3:0]  slot_s;
  logic [3:0]  slot_r;
  logic [3:0]  slot_next_s;
  logic [3:0]  psel_s;
  logic        penable_s;
  logic        hreadyout_s;

  function automatic logic [3:0] decode_slot(input logic [1:0] sel);
    logic [3:0] onehot;
    case (sel)
      2'b00:   onehot = 4'b0001;
      2'b01:   onehot = 4'b0010;
      2'b10:   onehot = 4'b0100;
      2'b11:   onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  // Transfer qualification; only NONSEQ/SEQ inside the window start an APB access
  always_comb begin
    valid_s     = Hreadyin && ((Htrans == 2'b10) || (Htrans == 2'b11)) && (Haddr[31:28] == 4'h8);
    accept_s    = Hreadyout && valid_s;
    slot_s      = decode_slot(Haddr[27:26]);
    slot_next_s = accept_s ? slot_s : slot_r;
  end

  // Next-state decision; ENABLE states may accept the next transfer without an IDLE gap
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_WENABLE, ST_RENABLE: begin
        if (valid_s && Hwrite) begin
          state_s = ST_WWAIT;
        end else if (valid_s) begin
          state_s = ST_RSETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WWAIT:  state_s = ST_WSETUP;
      ST_WSETUP: state_s = ST_WENABLE;
      ST_RSETUP: state_s = ST_RENABLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so the bus outputs come straight from flops
  always_comb begin
    psel_s      = 4'b0000;
    penable_s   = 1'b0;
    hreadyout_s = 1'b1;
    case (state_s)
      ST_IDLE: begin
        hreadyout_s = 1'b1;
      end
      ST_WWAIT: begin
        hreadyout_s = 1'b0;
      end
      ST_WSETUP, ST_RSETUP: begin
        psel_s      = slot_next_s;
        hreadyout_s = 1'b0;
      end
      ST_WENABLE, ST_RENABLE: begin
        psel_s      = slot_next_s;
        penable_s   = 1'b1;
      end
      default: begin
        hreadyout_s = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address-phase capture; Paddr/Pwrite hold until the next accepted transfer
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Paddr  <= 32'h0000_0000;
      Pwrite <= 1'b0;
      slot_r <= 4'b0000;
    end else if (accept_s) begin
      Paddr  <= Haddr;
      Pwrite <= Hwrite;
      slot_r <= slot_s;
    end
  end

  // Write data is taken in the AHB data phase, one cycle after the address
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Pwdata <= 32'h0000_0000;
    end else if (state_r == ST_WWAIT) begin
      Pwdata <= Hwdata;
    end
  end

  // Registered APB strobes and AHB ready
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Pselx     <= 4'b0000;
      Penable   <= 1'b0;
      Hreadyout <= 1'b1;
    end else begin
      Pselx     <= psel_s;
      Penable   <= penable_s;
      Hreadyout <= hreadyout_s;
    end
  end

  // Read data passes through only while the read ENABLE cycle is on the bus
  always_comb begin
    if (state_r == ST_RENABLE) begin
      Hrdata = Prdata;
    end else begin
      Hrdata = 32'h0000_0000;
    end
  end

  assign Hresp = 2'b00;

endmodule

// File: tb/tb_apb_modport_bridge.sv
// Self-checking bench for apb_modport_bridge: directed cases plus randomized traffic
// compared every cycle against a transaction-schedule model.
module tb_apb_modport_bridge;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  apb_modport_bridge dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata), .Pselx(Pselx),
    .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata)
  );

  always #5 Hclk = ~Hclk;

  // One expected bus cycle: ready, select, enable, direction, and whether Hwdata is sampled
  typedef struct packed {
    logic       rdy;
    logic [3:0] sel;
    logic       en;
    logic       wr;
    logic       cap;
  } cyc_t;

  cyc_t        sched[$];
  cyc_t        cur;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  int          vectors = 0;
  int          errors = 0;
  bit          checking = 1'b0;

  function automatic cyc_t mk(logic rdy, logic [3:0] sel, logic en, logic wr, logic cap);
    cyc_t c;
    c.rdy = rdy; c.sel = sel; c.en = en; c.wr = wr; c.cap = cap;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    cur      = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    m_paddr  = 32'h0;
    m_pwdata = 32'h0;
  endtask

  // An accepted write occupies wait, setup, enable; a read occupies setup, enable
  task automatic model_step();
    logic [3:0] s;
    if (cur.cap) m_pwdata = Hwdata;
    if (cur.rdy && Hreadyin && Htrans[1] && (Haddr[31:28] == 4'h8)) begin
      m_paddr = Haddr;
      s = 4'b0001 << Haddr[27:26];
      if (Hwrite) begin
        sched.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1));
        sched.push_back(mk(1'b0, s, 1'b0, 1'b1, 1'b0));
        sched.push_back(mk(1'b1, s, 1'b1, 1'b1, 1'b0));
      end else begin
        sched.push_back(mk(1'b0, s, 1'b0, 1'b0, 1'b0));
        sched.push_back(mk(1'b1, s, 1'b1, 1'b0, 1'b0));
      end
    end
    if (sched.size() > 0) cur = sched.pop_front();
    else cur = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Hclk);
    if (Hresetn) model_step();
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic ri);
    Htrans = tr; Haddr = a; Hwrite = w; Hreadyin = ri;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge Hclk) begin
    if (checking) begin
      chk("Hreadyout", {31'b0, Hreadyout}, {31'b0, cur.rdy});
      chk("Hresp", {30'b0, Hresp}, 32'h0);
      chk("Pselx", {28'b0, Pselx}, {28'b0, cur.sel});
      chk("Penable", {31'b0, Penable}, {31'b0, cur.en});
      chk("Paddr", Paddr, m_paddr);
      chk("Pwdata", Pwdata, m_pwdata);
      chk("Hrdata", Hrdata, (cur.en && !cur.wr) ? Prdata : 32'h0);
      if (cur.sel != 4'b0000) chk("Pwrite", {31'b0, Pwrite}, {31'b0, cur.wr});
    end
  end

  initial begin
    logic [3:0] sweep_exp [4];
    sweep_exp[0] = 4'b0001; sweep_exp[1] = 4'b0010; sweep_exp[2] = 4'b0100; sweep_exp[3] = 4'b1000;
    Hresetn = 1'b0;
    drive(2'b00, 32'h0, 1'b0, 1'b1);
    Hwdata = 32'h0; Prdata = 32'h0;
    model_reset();
    repeat (3) @(posedge Hclk);
    #1;
    chk("rst_Hreadyout", {31'b0, Hreadyout}, 32'h1);
    chk("rst_Pselx", {28'b0, Pselx}, 32'h0);
    chk("rst_Penable", {31'b0, Penable}, 32'h0);
    chk("rst_Paddr", Paddr, 32'h0);
    chk("rst_Hresp", {30'b0, Hresp}, 32'h0);
    checking = 1'b1;
    Hresetn = 1'b1;
    tick();

    // Single write
    drive(2'b10, 32'h8000_0010, 1'b1, 1'b1);
    tick();
    drive(2'b00, 32'h0, 1'b0, 1'b1); Hwdata = 32'hDEAD_BEEF;
    @(negedge Hclk); chk("wr_c1_ready", {31'b0, Hreadyout}, 32'h0);
    tick();
    @(negedge Hclk);
    chk("wr_c2_psel", {28'b0, Pselx}, 32'h1);
    chk("wr_c2_paddr", Paddr, 32'h8000_0010);
    chk("wr_c2_pwrite", {31'b0, Pwrite}, 32'h1);
    chk("wr_c2_penable", {31'b0, Penable}, 32'h0);
    tick();
    // Back-to-back read issued during WENABLE
    drive(2'b10, 32'h8400_0008, 1'b0, 1'b1);
    @(negedge Hclk);
    chk("wr_c3_penable", {31'b0, Penable}, 32'h1);
    chk("wr_c3_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("wr_c3_ready", {31'b0, Hreadyout}, 32'h1);
    tick();
    drive(2'b00, 32'h0, 1'b0, 1'b1);
    @(negedge Hclk);
    chk("b2b_psel", {28'b0, Pselx}, 32'h2);
    chk("b2b_penable", {31'b0, Penable}, 32'h0);
    chk("b2b_paddr", Paddr, 32'h8400_0008);
    @(posedge Hclk); #1;
    Hresetn = 1'b0;
    model_reset();
    #1;
    chk("arst_psel", {28'b0, Pselx}, 32'h0);
    chk("arst_penable", {31'b0, Penable}, 32'h0);
    chk("arst_ready", {31'b0, Hreadyout}, 32'h1);
    chk("arst_paddr", Paddr, 32'h0);
    chk("arst_pwdata", Pwdata, 32'h0);
    chk("arst_hrdata", Hrdata, 32'h0);
    tick();
    Hresetn = 1'b1;
    tick();

    // Single read
    drive(2'b10, 32'h8800_0004, 1'b0, 1'b1);
    tick();
    drive(2'b00, 32'h0, 1'b0, 1'b1); Prdata = 32'h1234_5678;
    @(negedge Hclk);
    chk("rd_c1_psel", {28'b0, Pselx}, 32'h4);
    chk("rd_c1_penable", {31'b0, Penable}, 32'h0);
    tick();
    @(negedge Hclk);
    chk("rd_c2_penable", {31'b0, Penable}, 32'h1);
    chk("rd_c2_hrdata", Hrdata, 32'h1234_5678);
    chk("rd_c2_ready", {31'b0, Hreadyout}, 32'h1);
    tick();

    // Decode sweep
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 32'h8000_0000 + (32'(i) << 26), 1'b0, 1'b1);
      tick();
      drive(2'b00, 32'h0, 1'b0, 1'b1);
      @(negedge Hclk);
      chk("sweep_psel", {28'b0, Pselx}, {28'b0, sweep_exp[i]});
      tick();
      tick();
    end

    // Ignored transfers
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(2'b10, 32'h7000_0000, 1'b1, 1'b1);
        1:       drive(2'b00, 32'h8000_0000, 1'b1, 1'b1);
        default: drive(2'b10, 32'h8000_0000, 1'b1, 1'b0);
      endcase
      tick();
      drive(2'b00, 32'h0, 1'b0, 1'b1);
      @(negedge Hclk);
      chk("ign_psel", {28'b0, Pselx}, 32'h0);
      chk("ign_ready", {31'b0, Hreadyout}, 32'h1);
      chk("ign_hresp", {30'b0, Hresp}, 32'h0);
      tick();
    end

    // Randomized traffic with one mid-run reset
    for (int n = 0; n < 800; n++) begin
      Htrans   = 2'($urandom_range(0, 3));
      Haddr    = {(($urandom_range(0, 9) < 8) ? 4'h8 : 4'($urandom_range(0, 15))), 28'($urandom)};
      Hwrite   = 1'($urandom_range(0, 1));
      Hreadyin = ($urandom_range(0, 7) != 0);
      Hwdata   = $urandom;
      Prdata   = $urandom;
      if (n == 400) begin
        Hresetn = 1'b0;
        model_reset();
      end else if (n == 402) begin
        Hresetn = 1'b1;
      end
      tick();
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
